riscv_conv_tile_fetch: RTL and testbench
========================================

Name: riscv_conv_tile_fetch

Overview:
Upstream feeder for the convolution unit. It gathers one 4x4 input tile (16 x 32-bit words) from data memory over an OBI-style load port, using a base address and a row stride. It presents the tile as a flat register array, indexed the same way as the unit's con_data[15:0], so that CON_OP no longer has to stream words through mem_rdata one at a time. It has no arithmetic beyond address generation.

Parameters:
MAX_OUT, 2, maximum outstanding granted-but-unanswered load requests (1..3)
TILE_DIM, 4, tile edge length; only 4 is supported and the elaborated word count is TILE_DIM*TILE_DIM = 16

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle request to fetch a tile; sampled only in IDLE
base_addr_i  in  32  byte address of tile word 0; sampled on start
row_stride_i  in  32  byte distance between tile rows; sampled on start
busy_o  out  1  high from the cycle after start until done_o
done_o  out  1  one-cycle pulse when the fetch ends
tile_valid_o  out  1  tile_o holds a complete, error-free tile
err_o  out  1  sticky error for the last fetch
tile_o  out  16x32  tile words; index k = 4*row + col
data_req_o  out  1  load request
data_addr_o  out  32  load byte address
data_we_o  out  1  tied 0
data_be_o  out  4  tied 4'hF
data_gnt_i  in  1  request accepted this cycle
data_rvalid_i  in  1  response valid
data_rdata_i  in  32  response data
data_err_i  in  1  response error, qualified by rvalid

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; tile_o all 0.
  - State IDLE; counters and latched operands cleared.
- States and transitions:
  - IDLE -> FETCH on start_i.
  - FETCH -> DRAIN once the 16th request is granted.
  - DRAIN -> DONE once the 16th response arrives.
  - DONE -> IDLE unconditionally after one cycle.
- Start handling:
  - start_i outside IDLE is ignored.
  - On an accepted start, latch base and stride, clear err_o and tile_valid_o, and zero req_cnt, rsp_cnt and outstanding.
  - tile_o keeps its old contents until overwritten.
- Alignment check:
  - If base_addr_i[1:0] != 0 or row_stride_i[1:0] != 0 at start: go IDLE -> DONE, issue no requests, set err_o=1, pulse done_o.
- Request sequence:
  - Request k goes to base + (k>>2)*stride + (k&3)*4, with 32-bit modulo (wrap-around) arithmetic.
  - Issue in strictly increasing k.
- Request rules:
  - data_req_o=1 in FETCH while req_cnt<16 and outstanding<MAX_OUT. Outstanding is evaluated as the registered count; a same-cycle rvalid does not free a slot until the next cycle.
  - Once raised, data_req_o and data_addr_o hold stable until data_gnt_i.
  - A grant increments req_cnt and outstanding.
  - data_gnt_i while data_req_o=0 is ignored.
- Response rules:
  - Responses return in order. An rvalid with outstanding>0 writes tile_o[rsp_cnt] = data_rdata_i, increments rsp_cnt and decrements outstanding.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
  - An rvalid with outstanding==0 is dropped (stale response from before a reset).
- Error response (data_err_i with rvalid):
  - Set err_o.
  - Do not write that tile word.
  - Still count the response; the fetch completes normally.
- Completion:
  - The DONE cycle asserts done_o=1 and busy_o=0.
  - tile_valid_o = !err_o from the DONE cycle onward; it holds until the next accepted start or reset.
- Latency: with gnt tied 1 and rvalid one cycle after gnt, start to done_o takes 18 cycles.
- Reset mid-fetch: abort immediately with no done_o. A start in the first cycle after reset release is accepted.

Test Plan:
- Basic fetch: base=0x1000, stride=0x40, zero-wait memory, mem[a]=a -> addresses 0x1000, 0x1004, ..., 0x10CC in order; tile_o[5]=0x1044; done_o exactly 18 cycles after start; tile_valid_o=1; err_o=0.
- Backpressure: random gnt stalls (30%) and rvalid delays of 1-4 cycles, MAX_OUT=2 -> outstanding never exceeds 2; addr stable while req && !gnt; tile_o matches golden.
- Error response: data_err_i on response 7 -> err_o=1, tile_valid_o=0, tile_o[7] keeps its previous value, done_o still pulses once.
- Misaligned start: base=0x1002 -> no data_req_o, done_o one cycle after start, err_o=1. Stride=0x3E gives the same result.
- Wrap and ignore: base=0xFFFF_FFF0, stride=0x10 -> word 4 address is 0x0000_0000; a start_i pulse during FETCH is ignored and no second done_o occurs.
- Reset mid-fetch: assert rst after 6 grants, release, then deliver one stale rvalid -> outputs 0 and rvalid dropped; a fresh start then completes correctly.

Source files
------------

// File: rtl/riscv_conv_tile_fetch.sv
`default_nettype none
// ============================================================================
// Module   : riscv_conv_tile_fetch
// Purpose  : Gathers one TILE_DIM x TILE_DIM tile of 32-bit words from data
//            memory over an OBI-style load port. Word k is read from
//            base + (k / TILE_DIM) * stride + (k % TILE_DIM) * 4 and is
//            presented on tile_o, indexed k = 4*row + col, matching the
//            convolution unit's con_data[15:0] ordering.
// Ports    : clk, rst            - clock / asynchronous active-high reset
//            start_i             - fetch request, honoured only in IDLE
//            base_addr_i         - byte address of tile word 0
//            row_stride_i        - byte distance between tile rows
//            busy_o, done_o      - fetch in progress / one-cycle completion
//            tile_valid_o, err_o - tile complete and clean / sticky error
//            tile_o              - flat tile, word k at [32*k +: 32]
//            data_*              - OBI load port (req/gnt, rvalid/rdata/err)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_conv_tile_fetch #(
    parameter int MAX_OUT  = 2,   // outstanding granted loads, 1..3
    parameter int TILE_DIM = 4    // only 4 is supported
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    input  wire logic                            start_i,
    input  wire logic [31:0]                     base_addr_i,
    input  wire logic [31:0]                     row_stride_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 tile_valid_o,
    output logic                                 err_o,
    output logic [TILE_DIM*TILE_DIM*32-1:0]      tile_o,
    output logic                                 data_req_o,
    output logic [31:0]                          data_addr_o,
    output logic                                 data_we_o,
    output logic [3:0]                           data_be_o,
    input  wire logic                            data_gnt_i,
    input  wire logic                            data_rvalid_i,
    input  wire logic [31:0]                     data_rdata_i,
    input  wire logic                            data_err_i
);

    localparam int               WORDS     = TILE_DIM * TILE_DIM;
    localparam int               CNT_W     = $clog2(WORDS + 1);
    localparam int               IDX_W     = $clog2(WORDS);
    localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
    localparam logic [1:0]       MAX_OUT_C = 2'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   req_cnt_q;
    logic [CNT_W-1:0]   rsp_cnt_q;
    logic [1:0]         out_q;
    logic [31:0]        row_base_q;   // address of column 0 of the current request row
    logic [31:0]        stride_q;
    logic               busy_q;
    logic               done_q;
    logic               tile_valid_q;
    logic               err_q;
    logic [31:0]        tile_q [WORDS];

    logic               gnt_fire;
    logic               rsp_fire;
    logic               err_d;
    logic               misaligned;

    // Request eligibility uses only registered state, so a response in the
    // same cycle cannot open a slot early and the request stays stable
    // until it is granted.
    assign data_req_o  = (state_q == S_FETCH) && (req_cnt_q < WORDS_C) &&
                         (out_q < MAX_OUT_C);
    // Row base advances on the column-3 grant, so only the column offset is
    // added here and no multiplier is needed.
    assign data_addr_o = row_base_q + {28'd0, req_cnt_q[1:0], 2'b00};
    assign data_we_o   = 1'b0;
    assign data_be_o   = 4'hF;

    assign gnt_fire   = data_req_o & data_gnt_i;
    // A response with nothing outstanding is a leftover from before a reset.
    assign rsp_fire   = data_rvalid_i & (out_q != 2'd0);
    assign err_d      = err_q | (rsp_fire & data_err_i);
    assign misaligned = (base_addr_i[1:0] != 2'b00) || (row_stride_i[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            out_q        <= 2'd0;
            row_base_q   <= 32'd0;
            stride_q     <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tile_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                tile_q[k] <= 32'd0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= err_d;

            if (gnt_fire) begin
                req_cnt_q <= req_cnt_q + 1'b1;
                if (req_cnt_q[1:0] == 2'b11) begin
                    row_base_q <= row_base_q + stride_q;
                end
            end

            if (rsp_fire) begin
                rsp_cnt_q <= rsp_cnt_q + 1'b1;
                // An errored word is counted but leaves the old contents.
                if (!data_err_i) begin
                    tile_q[rsp_cnt_q[IDX_W-1:0]] <= data_rdata_i;
                end
            end

            // Simultaneous grant and response leave the count unchanged.
            if (gnt_fire && !rsp_fire) begin
                out_q <= out_q + 2'd1;
            end else if (!gnt_fire && rsp_fire) begin
                out_q <= out_q - 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        req_cnt_q    <= '0;
                        rsp_cnt_q    <= '0;
                        out_q        <= 2'd0;
                        row_base_q   <= base_addr_i;
                        stride_q     <= row_stride_i;
                        tile_valid_q <= 1'b0;
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (gnt_fire && (req_cnt_q == LAST_IDX)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rsp_fire && (rsp_cnt_q == LAST_IDX)) begin
                        state_q      <= S_DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        tile_valid_q <= ~err_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < WORDS; k++) begin : g_tile
            assign tile_o[k*32 +: 32] = tile_q[k];
        end
    endgenerate

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign tile_valid_o = tile_valid_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_conv_tile_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_conv_tile_fetch
// Purpose  : Directed self-checking bench for riscv_conv_tile_fetch. A
//            memory responder returns (addr ^ salt) in order with
//            configurable grant stalls, response latency and error
//            injection, and logs every accepted request address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_conv_tile_fetch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [31:0]  base_addr_i = 32'd0;
    logic [31:0]  row_stride_i = 32'd0;
    logic         busy_o, done_o, tile_valid_o, err_o;
    logic [511:0] tile_o;
    logic         data_req_o, data_we_o;
    logic [31:0]  data_addr_o;
    logic [3:0]   data_be_o;
    logic         data_gnt_i = 1'b0;
    logic         data_rvalid_i = 1'b0;
    logic [31:0]  data_rdata_i = 32'd0;
    logic         data_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_conv_tile_fetch #(.MAX_OUT(2), .TILE_DIM(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .base_addr_i(base_addr_i), .row_stride_i(row_stride_i),
        .busy_o(busy_o), .done_o(done_o), .tile_valid_o(tile_valid_o),
        .err_o(err_o), .tile_o(tile_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    // ---------------- memory responder ----------------
    bit           stall_en   = 1'b0;
    int           lat_mode   = 0;
    logic [31:0]  salt       = 32'd0;
    int           err_target = -1;
    int           stale_req  = 0;
    int           stale_done = 0;
    int           cyc        = 0;
    int           gtotal     = 0;
    int           resp_total = 0;
    int           max_out    = 0;
    int           stab_viol  = 0;
    logic [31:0]  glog [256];
    logic [31:0]  pq_addr [$];
    int           pq_ready [$];
    logic         last_req = 1'b0, last_gnt = 1'b0, last_rvalid = 1'b0, last_stale = 1'b0;
    logic [31:0]  last_addr = 32'd0;

    function automatic int lat_for(int idx);
        if (lat_mode == 1) return 1 + (idx % 4);
        if (lat_mode == 2) return 3;
        return 1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pq_addr.delete();
            pq_ready.delete();
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = 32'd0;
            last_req      = 1'b0;
            last_gnt      = 1'b0;
            last_rvalid   = 1'b0;
            last_stale    = 1'b0;
        end else begin
            if (last_req && last_gnt) begin
                if (gtotal < 256) glog[gtotal] = last_addr;
                pq_addr.push_back(last_addr);
                pq_ready.push_back(cyc + lat_for(gtotal) - 1);
                gtotal++;
            end
            if (last_rvalid && !last_stale && pq_addr.size() > 0) begin
                void'(pq_addr.pop_front());
                void'(pq_ready.pop_front());
                resp_total++;
            end
            if (pq_addr.size() > max_out) max_out = pq_addr.size();
            if (last_req && !last_gnt && (!data_req_o || data_addr_o != last_addr))
                stab_viol++;

            data_gnt_i    = stall_en ? ((cyc % 10) >= 3) : 1'b1;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = 32'd0;
            last_stale    = 1'b0;
            if (stale_req != stale_done) begin
                stale_done    = stale_req;
                data_rvalid_i = 1'b1;
                data_rdata_i  = 32'hDEAD_BEEF;
                last_stale    = 1'b1;
            end else if (pq_addr.size() > 0 && pq_ready[0] <= cyc) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = pq_addr[0] ^ salt;
                data_err_i    = (resp_total == err_target);
            end
            last_req    = data_req_o;
            last_gnt    = data_gnt_i;
            last_addr   = data_addr_o;
            last_rvalid = data_rvalid_i;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] exp_tile [16];

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_addr(logic [31:0] b, logic [31:0] s, int k);
        return b + (32'(k >> 2) * s) + 32'((k & 3) * 4);
    endfunction

    function automatic void set_exp(logic [31:0] b, logic [31:0] s, int skip);
        for (int k = 0; k < 16; k++)
            if (k != skip) exp_tile[k] = word_addr(b, s, k) ^ salt;
    endfunction

    // Pulses start, then counts cycles until done_o; keeps watching for
    // 20 cycles afterwards to count any extra done pulse.
    task automatic do_fetch(input logic [31:0] b, input logic [31:0] s, input int ignore_at,
                            output int lat, output int ndone, output int g0, output int ngr,
                            output logic busy1);
        g0 = gtotal;
        base_addr_i  = b;
        row_stride_i = s;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        lat = -1;
        ndone = 0;
        busy1 = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (n == 1) busy1 = busy_o;
            if (done_o) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 20) break;
            start_i = (n == ignore_at);
            tick;
        end
        start_i = 1'b0;
        ngr = gtotal - g0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        tick;
        tick;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (tile_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tile_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", data_req_o); end
        checks++; if (data_addr_o !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", data_addr_o); end
        checks++; if (tile_o !== 512'd0) begin errors++; $display("FAIL reset_tile: got nonzero expected 0"); end
        checks++; if (data_we_o !== 1'b0 || data_be_o !== 4'hF) begin errors++; $display("FAIL tie_we_be: got %b/%h expected 0/f", data_we_o, data_be_o); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int lat, nd, g0, ngr; logic b1;
        stall_en = 1'b0; lat_mode = 0; salt = 32'd0; err_target = -1;
        do_fetch(32'h1000, 32'h40, 0, lat, nd, g0, ngr, b1);
        set_exp(32'h1000, 32'h40, -1);
        checks++; if (lat != 18) begin errors++; $display("FAIL basic_latency: got %0d expected 18", lat); end
        checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", b1); end
        checks++; if (ngr != 16) begin errors++; $display("FAIL basic_grants: got %0d expected 16", ngr); end
        for (int i = 0; i < 16 && i < ngr; i++) begin
            checks++;
            if (glog[g0+i] !== word_addr(32'h1000, 32'h40, i)) begin errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, glog[g0+i], word_addr(32'h1000, 32'h40, i)); end
        end
        checks++; if (ngr >= 16 && glog[g0+15] !== 32'h0000_10CC) begin errors++; $display("FAIL basic_last_addr: got %h expected 000010cc", glog[g0+15]); end
        checks++; if (tile_o[5*32 +: 32] !== 32'h0000_1044) begin errors++; $display("FAIL basic_tile5: got %h expected 00001044", tile_o[5*32 +: 32]); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tile_o[k*32 +: 32] !== exp_tile[k]) begin errors++; $display("FAIL basic_tile[%0d]: got %h expected %h", k, tile_o[k*32 +: 32], exp_tile[k]); end
        end
        checks++; if (tile_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", tile_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy_o); end
    endtask

    task automatic test_backpressure;
        int lat, nd, g0, ngr; logic b1;
        stall_en = 1'b1; lat_mode = 1; salt = 32'hA5A5_0000;
        do_fetch(32'h2000, 32'h100, 0, lat, nd, g0, ngr, b1);
        set_exp(32'h2000, 32'h100, -1);
        stall_en = 1'b0; lat_mode = 0;
        checks++; if (lat < 18) begin errors++; $display("FAIL bp_latency: got %0d expected >=18", lat); end
        checks++; if (nd != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", nd); end
        checks++; if (ngr != 16) begin errors++; $display("FAIL bp_grants: got %0d expected 16", ngr); end
        for (int i = 0; i < 16 && i < ngr; i++) begin
            checks++;
            if (glog[g0+i] !== word_addr(32'h2000, 32'h100, i)) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, glog[g0+i], word_addr(32'h2000, 32'h100, i)); end
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tile_o[k*32 +: 32] !== exp_tile[k]) begin errors++; $display("FAIL bp_tile[%0d]: got %h expected %h", k, tile_o[k*32 +: 32], exp_tile[k]); end
        end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d expected <=2", max_out); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_req_stable: got %0d violations expected 0", stab_viol); end
        checks++; if (tile_valid_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL bp_status: got valid=%b err=%b expected 1/0", tile_valid_o, err_o); end
    endtask

    task automatic test_error;
        int lat, nd, g0, ngr; logic b1;
        salt = 32'h5555_5555;
        err_target = resp_total + 7;
        do_fetch(32'h1000, 32'h40, 0, lat, nd, g0, ngr, b1);
        err_target = -1;
        set_exp(32'h1000, 32'h40, 7);   // word 7 keeps the backpressure value
        checks++; if (lat != 18) begin errors++; $display("FAIL err_latency: got %0d expected 18", lat); end
        checks++; if (nd != 1) begin errors++; $display("FAIL err_done_count: got %0d expected 1", nd); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", err_o); end
        checks++; if (tile_valid_o !== 1'b0) begin errors++; $display("FAIL err_valid: got %b expected 0", tile_valid_o); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tile_o[k*32 +: 32] !== exp_tile[k]) begin errors++; $display("FAIL err_tile[%0d]: got %h expected %h", k, tile_o[k*32 +: 32], exp_tile[k]); end
        end
    endtask

    task automatic test_misaligned;
        int lat, nd, g0, ngr; logic b1;
        logic [31:0] bases [2];
        logic [31:0] strides [2];
        bases[0] = 32'h1002; strides[0] = 32'h40;
        bases[1] = 32'h1000; strides[1] = 32'h3E;
        for (int t = 0; t < 2; t++) begin
            do_fetch(bases[t], strides[t], 0, lat, nd, g0, ngr, b1);
            checks++; if (lat != 1) begin errors++; $display("FAIL mis%0d_latency: got %0d expected 1", t, lat); end
            checks++; if (nd != 1) begin errors++; $display("FAIL mis%0d_done_count: got %0d expected 1", t, nd); end
            checks++; if (ngr != 0) begin errors++; $display("FAIL mis%0d_grants: got %0d expected 0", t, ngr); end
            checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL mis%0d_busy: got %b expected 0", t, b1); end
            checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mis%0d_err: got %b expected 1", t, err_o); end
            checks++; if (tile_valid_o !== 1'b0) begin errors++; $display("FAIL mis%0d_valid: got %b expected 0", t, tile_valid_o); end
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tile_o[k*32 +: 32] !== exp_tile[k]) begin errors++; $display("FAIL mis_tile[%0d]: got %h expected %h", k, tile_o[k*32 +: 32], exp_tile[k]); end
        end
    endtask

    task automatic test_wrap_ignore;
        int lat, nd, g0, ngr; logic b1;
        salt = 32'h0F0F_0000;
        do_fetch(32'hFFFF_FFF0, 32'h10, 5, lat, nd, g0, ngr, b1);
        set_exp(32'hFFFF_FFF0, 32'h10, -1);
        checks++; if (lat != 18) begin errors++; $display("FAIL wrap_latency: got %0d expected 18", lat); end
        checks++; if (nd != 1) begin errors++; $display("FAIL wrap_done_count: got %0d expected 1", nd); end
        checks++; if (ngr != 16) begin errors++; $display("FAIL wrap_grants: got %0d expected 16", ngr); end
        checks++; if (ngr >= 5 && glog[g0+4] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr4: got %h expected 00000000", glog[g0+4]); end
        for (int i = 0; i < 16 && i < ngr; i++) begin
            checks++;
            if (glog[g0+i] !== word_addr(32'hFFFF_FFF0, 32'h10, i)) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, glog[g0+i], word_addr(32'hFFFF_FFF0, 32'h10, i)); end
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tile_o[k*32 +: 32] !== exp_tile[k]) begin errors++; $display("FAIL wrap_tile[%0d]: got %h expected %h", k, tile_o[k*32 +: 32], exp_tile[k]); end
        end
        checks++; if (tile_valid_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL wrap_status: got valid=%b err=%b expected 1/0", tile_valid_o, err_o); end
    endtask

    task automatic test_reset_mid;
        int lat, nd, g0, ngr; logic b1; int waited;
        lat_mode = 2; salt = 32'h1234_0000;
        g0 = gtotal;
        base_addr_i = 32'h3000; row_stride_i = 32'h20;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        waited = 0;
        while ((gtotal - g0) < 6 && waited < 100) begin
            tick;
            waited++;
        end
        checks++; if ((gtotal - g0) < 6) begin errors++; $display("FAIL mid_reach6: got %0d grants expected 6", gtotal - g0); end
        rst = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy_done: got %b/%b expected 0/0", busy_o, done_o); end
        checks++; if (tile_valid_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid_err: got %b/%b expected 0/0", tile_valid_o, err_o); end
        checks++; if (data_req_o !== 1'b0 || data_addr_o !== 32'd0) begin errors++; $display("FAIL mid_rst_req_addr: got %b/%h expected 0/0", data_req_o, data_addr_o); end
        checks++; if (tile_o !== 512'd0) begin errors++; $display("FAIL mid_rst_tile: got nonzero expected 0"); end
        tick;
        rst = 1'b0;
        stale_req++;
        tick; tick; tick;
        checks++; if (tile_o !== 512'd0) begin errors++; $display("FAIL mid_stale_tile: got word0=%h expected 0", tile_o[31:0]); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || data_req_o !== 1'b0) begin errors++; $display("FAIL mid_stale_idle: got busy=%b done=%b req=%b expected 0", busy_o, done_o, data_req_o); end
        lat_mode = 0; salt = 32'h7777_0000;
        do_fetch(32'h0400, 32'h80, 0, lat, nd, g0, ngr, b1);
        set_exp(32'h0400, 32'h80, -1);
        checks++; if (lat != 18) begin errors++; $display("FAIL mid_fresh_latency: got %0d expected 18", lat); end
        checks++; if (nd != 1 || ngr != 16) begin errors++; $display("FAIL mid_fresh_counts: got done=%0d grants=%0d expected 1/16", nd, ngr); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tile_o[k*32 +: 32] !== exp_tile[k]) begin errors++; $display("FAIL mid_fresh_tile[%0d]: got %h expected %h", k, tile_o[k*32 +: 32], exp_tile[k]); end
        end
        checks++; if (tile_valid_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL mid_fresh_status: got valid=%b err=%b expected 1/0", tile_valid_o, err_o); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_error;
        test_misaligned;
        test_wrap_ignore;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
